route_lock_unit: RTL and testbench
==================================

ROUTE_LOCK_UNIT -- requirements
Module: route_lock_unit

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- TAM_FLIT, 16, flit width.
- COORD_W, 2, width of each destination coordinate field.
- DEST_MSB, 15, MSB of the X field in the header; Y field sits directly below X.
- LOCAL_X, 0, router X coordinate.
- LOCAL_Y, 0, router Y coordinate.
- MESH_X, 4, mesh columns.
- MESH_Y, 4, mesh rows.
- MODE, 0, 0 = XY routing, 1 = YX routing.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, the single clock.
- rst, in, 1, synchronous, active-high reset.
- i_flit, in, TAM_FLIT, input buffer head flit.
- i_valid, in, 1, i_flit holds valid data.
- i_ready, in, 1, downstream accepts the flit this cycle.
- o_outputPort, out, 5, one-hot granted output port.
- o_route_valid, out, 1, route locked and flits may be forwarded.
- o_busy, out, 1, the FSM is not in IDLE.
- o_err, out, 1, one-cycle pulse for an out-of-mesh destination.
REQ-003 Port bit indices SHALL be EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
REQ-004 All outputs SHALL be registered.
REQ-005 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-006 A transfer SHALL be defined as i_valid & i_ready & o_route_valid; i_ready SHALL be ignored whenever o_route_valid=0.
REQ-007 The FSM SHALL have the states IDLE, ROUTE, HEADER, SIZE and PAYLOAD.
REQ-008 IDLE: on i_valid=1, the block SHALL latch dest_x = i_flit[DEST_MSB -: COORD_W] and dest_y = the next COORD_W bits below it, then go to ROUTE.
REQ-009 ROUTE: the block SHALL compute the port, register o_outputPort, set o_route_valid=1 and go to HEADER; this gives a route latency of 2 cycles from the first IDLE cycle with i_valid=1.
REQ-010 In XY mode: dest_x>LOCAL_X selects EAST, dest_x<LOCAL_X selects WEST, otherwise dest_y<LOCAL_Y selects SOUTH, dest_y>LOCAL_Y selects NORTH, otherwise LOCAL.
REQ-011 In YX mode the Y comparison SHALL be resolved before the X comparison, using the same port mapping.
REQ-012 All coordinate comparisons SHALL be unsigned and COORD_W bits wide.
REQ-013 If dest_x>=MESH_X or dest_y>=MESH_Y, the block SHALL select LOCAL and pulse o_err for exactly the ROUTE-exit cycle.
REQ-014 HEADER: on a transfer, the block SHALL go to SIZE.
REQ-015 SIZE: on a transfer, the block SHALL load a 16-bit counter with i_flit[15:0], treated as zero-extended or truncated to 16 bits.
REQ-016 If the loaded size is 0, the block SHALL release the route and go to IDLE; otherwise it SHALL go to PAYLOAD.
REQ-017 PAYLOAD: each transfer SHALL decrement the counter; the transfer made with counter==1 SHALL release the route and return to IDLE.
REQ-018 Release SHALL set o_route_valid=0 and o_outputPort=0 in the cycle after the last transfer.
REQ-019 o_outputPort SHALL stay constant while o_route_valid=1.
REQ-020 o_outputPort SHALL be all-zero whenever o_route_valid=0.
REQ-021 i_valid=1 with i_ready=0 SHALL cause no state or counter change.
REQ-022 Back-to-back packets SHALL be supported: IDLE may accept a new header in the cycle right after release, which gives one idle bubble per packet.
REQ-023 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL enter IDLE and set o_outputPort=0, o_route_valid=0, o_busy=0, o_err=0 and the counter to 0.
REQ-025 Reset asserted in any state, including mid-packet, SHALL abandon the packet with no further transfers counted.
REQ-026 The first header SHALL be sampled in the first cycle with rst=0.

Verification
REQ-027 LOCAL_X=1, LOCAL_Y=1, MODE=0, header dest (3,0), size 2 -> o_outputPort=00001 (EAST) two cycles after the header; o_route_valid drops one cycle after the 4th transfer.
REQ-028 Same header with MODE=1 -> o_outputPort=01000 (SOUTH).
REQ-029 dest (1,1), size 0 -> LOCAL (10000); route released after 2 transfers (header and size).
REQ-030 MESH_X=3, dest (3,1) -> o_outputPort=10000 and o_err high for exactly 1 cycle.
REQ-031 Size 3 with i_ready toggling 1,0,0,1,1,0,1 -> release exactly after the 5th accepted transfer; o_outputPort stable throughout.
REQ-032 rst pulsed during PAYLOAD -> all outputs 0 next cycle; a new header afterwards routes correctly.

Source files
------------

// File: rtl/route_lock_unit.sv
// route_lock_unit: wormhole route computation and lock for one input port of a
// 2D mesh router. The head flit's destination is latched, an XY or YX output port
// is computed and held one-hot. The lock is released once the header, the size
// flit and <size> payload flits have been transferred.
//
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   i_flit        head flit of the input buffer
//   i_valid       i_flit holds valid data
//   i_ready       downstream accepts the flit this cycle
//   o_outputPort  one-hot granted port (E=0, W=1, N=2, S=3, L=4); zero when unlocked
//   o_route_valid route locked, flits may be forwarded
//   o_busy        FSM not in IDLE
//   o_err         one-cycle pulse when the destination lies outside the mesh
module route_lock_unit #(
  parameter int TAM_FLIT = 16,
  parameter int COORD_W  = 2,
  parameter int DEST_MSB = 15,
  parameter int LOCAL_X  = 0,
  parameter int LOCAL_Y  = 0,
  parameter int MESH_X   = 4,
  parameter int MESH_Y   = 4,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TAM_FLIT-1:0] i_flit,
  input  logic                i_valid,
  input  logic                i_ready,
  output logic [4:0]          o_outputPort,
  output logic                o_route_valid,
  output logic                o_busy,
  output logic                o_err
);

  localparam logic [4:0] P_EAST  = 5'b00001;
  localparam logic [4:0] P_WEST  = 5'b00010;
  localparam logic [4:0] P_NORTH = 5'b00100;
  localparam logic [4:0] P_SOUTH = 5'b01000;
  localparam logic [4:0] P_LOCAL = 5'b10000;

  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

  typedef enum logic [2:0] {IDLE, ROUTE, HEADER, SIZE, PAYLOAD} state_t;

  state_t             state, state_nx;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic [15:0]        cnt, size_in;
  logic [4:0]         x_port, y_port, route_port;
  logic               xfer, release_rt, out_of_mesh;

  // Downstream ready only counts while the route is locked.
  assign xfer = i_valid & i_ready & o_route_valid;

  generate
    if (TAM_FLIT >= 16) begin : g_size_trunc
      assign size_in = i_flit[15:0];
    end else begin : g_size_zext
      assign size_in = {{(16-TAM_FLIT){1'b0}}, i_flit};
    end
  endgenerate

  // Mesh bounds are checked at 32 bits: a bound such as MESH_X=4 does not fit
  // in a 2-bit coordinate and would wrap to zero.
  assign out_of_mesh = (32'(dest_x) >= 32'(MESH_X)) || (32'(dest_y) >= 32'(MESH_Y));

  always_comb begin
    x_port = '0;
    y_port = '0;
    if (dest_x > LX)      x_port = P_EAST;
    else if (dest_x < LX) x_port = P_WEST;
    if (dest_y < LY)      y_port = P_SOUTH;
    else if (dest_y > LY) y_port = P_NORTH;

    route_port = P_LOCAL;
    if (out_of_mesh)       route_port = P_LOCAL;
    else if (MODE == 0)    route_port = (x_port != '0) ? x_port : (y_port != '0) ? y_port : P_LOCAL;
    else                   route_port = (y_port != '0) ? y_port : (x_port != '0) ? x_port : P_LOCAL;
  end

  always_comb begin
    state_nx   = state;
    release_rt = 1'b0;
    case (state)
      IDLE:    if (i_valid) state_nx = ROUTE;
      ROUTE:   state_nx = HEADER;
      HEADER:  if (xfer) state_nx = SIZE;
      SIZE:    if (xfer) begin
                 if (size_in == 16'd0) begin
                   state_nx   = IDLE;
                   release_rt = 1'b1;
                 end else begin
                   state_nx = PAYLOAD;
                 end
               end
      PAYLOAD: if (xfer && cnt == 16'd1) begin
                 state_nx   = IDLE;
                 release_rt = 1'b1;
               end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dest_x        <= '0;
      dest_y        <= '0;
      cnt           <= '0;
      o_outputPort  <= '0;
      o_route_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state  <= state_nx;
      o_busy <= (state_nx != IDLE);
      o_err  <= 1'b0;
      if (state == IDLE && i_valid) begin
        dest_x <= i_flit[DEST_MSB -: COORD_W];
        dest_y <= i_flit[DEST_MSB-COORD_W -: COORD_W];
      end
      if (state == ROUTE) begin
        o_outputPort  <= route_port;
        o_route_valid <= 1'b1;
        o_err         <= out_of_mesh;
      end
      if (release_rt) begin
        o_outputPort  <= '0;
        o_route_valid <= 1'b0;
      end
      if (state == SIZE && xfer)         cnt <= size_in;
      else if (state == PAYLOAD && xfer) cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_route_lock_unit.sv
module tb_route_lock_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_flit;
  logic        i_valid, i_ready;
  logic [4:0]  port0, port1, port2;
  logic        rv0, rv1, rv2, busy0, busy1, busy2, err0, err1, err2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // XY router at (1,1)
  route_lock_unit #(.LOCAL_X(1), .LOCAL_Y(1), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .i_flit(i_flit), .i_valid(i_valid), .i_ready(i_ready),
    .o_outputPort(port0), .o_route_valid(rv0), .o_busy(busy0), .o_err(err0));
  // YX router at (1,1)
  route_lock_unit #(.LOCAL_X(1), .LOCAL_Y(1), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .i_flit(i_flit), .i_valid(i_valid), .i_ready(i_ready),
    .o_outputPort(port1), .o_route_valid(rv1), .o_busy(busy1), .o_err(err1));
  // XY router at (1,1) in a 3-column mesh
  route_lock_unit #(.LOCAL_X(1), .LOCAL_Y(1), .MODE(0), .MESH_X(3)) dut2 (
    .clk(clk), .rst(rst), .i_flit(i_flit), .i_valid(i_valid), .i_ready(i_ready),
    .o_outputPort(port2), .o_route_valid(rv2), .o_busy(busy2), .o_err(err2));

  // Drive inputs, then advance one edge; outputs are examined 1 time unit later.
  task automatic cyc(input logic [15:0] f, input logic v, input logic r);
    i_flit = f; i_valid = v; i_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'hC000, 1'b1, 1'b1);
    checks++;
    if ({port0, rv0, busy0, err0} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b expected 00000000", {port0, rv0, busy0, err0});
    end
    rst = 1'b0;
  endtask

  // dest (3,0), size 2: XY -> EAST, YX -> SOUTH
  task automatic test_xy_yx();
    cyc(16'hC000, 1'b1, 1'b1);            // first cycle out of reset samples header
    checks++;
    if (rv0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL route_latency1 got rv=%b busy=%b expected rv=0 busy=1", rv0, busy0);
    end
    cyc(16'hC000, 1'b1, 1'b1);            // ROUTE -> HEADER
    checks++;
    if (port0 !== 5'b00001 || rv0 !== 1'b1) begin
      errors++; $display("FAIL xy_east got port=%b rv=%b expected 00001 1", port0, rv0);
    end
    checks++;
    if (port1 !== 5'b01000) begin
      errors++; $display("FAIL yx_south got %b expected 01000", port1);
    end
    cyc(16'hC000, 1'b1, 1'b1);            // transfer 1: header
    cyc(16'h0002, 1'b1, 1'b1);            // transfer 2: size
    cyc(16'hAAAA, 1'b1, 1'b1);            // transfer 3
    checks++;
    if (rv0 !== 1'b1 || port0 !== 5'b00001) begin
      errors++; $display("FAIL xy_hold got port=%b rv=%b expected 00001 1", port0, rv0);
    end
    cyc(16'h5555, 1'b1, 1'b1);            // transfer 4
    checks++;
    if (rv0 !== 1'b0 || port0 !== 5'b00000 || busy0 !== 1'b0) begin
      errors++; $display("FAIL xy_release got port=%b rv=%b busy=%b expected 00000 0 0", port0, rv0, busy0);
    end
    cyc(16'h0000, 1'b0, 1'b0);
  endtask

  // dest (1,1), size 0: LOCAL, released after header + size
  task automatic test_local_size0();
    cyc(16'h5000, 1'b1, 1'b1);
    cyc(16'h5000, 1'b1, 1'b1);
    checks++;
    if (port0 !== 5'b10000 || rv0 !== 1'b1) begin
      errors++; $display("FAIL local_port got port=%b rv=%b expected 10000 1", port0, rv0);
    end
    cyc(16'h5000, 1'b1, 1'b1);            // header
    checks++;
    if (rv0 !== 1'b1) begin
      errors++; $display("FAIL local_after_hdr got rv=%b expected 1", rv0);
    end
    cyc(16'h0000, 1'b1, 1'b1);            // size 0
    checks++;
    if (rv0 !== 1'b0 || port0 !== 5'b00000) begin
      errors++; $display("FAIL size0_release got port=%b rv=%b expected 00000 0", port0, rv0);
    end
    cyc(16'h0000, 1'b0, 1'b0);
  endtask

  // dest (3,1) with MESH_X=3: LOCAL plus a single-cycle error pulse
  task automatic test_out_of_mesh();
    cyc(16'hD000, 1'b1, 1'b1);
    cyc(16'hD000, 1'b1, 1'b0);            // hold the header so the pulse can be watched
    checks++;
    if (port2 !== 5'b10000 || err2 !== 1'b1) begin
      errors++; $display("FAIL oom_port got port=%b err=%b expected 10000 1", port2, err2);
    end
    checks++;
    if (port0 !== 5'b00001 || err0 !== 1'b0) begin
      errors++; $display("FAIL inmesh_east got port=%b err=%b expected 00001 0", port0, err0);
    end
    cyc(16'hD000, 1'b1, 1'b1);            // header transfer
    checks++;
    if (err2 !== 1'b0 || port2 !== 5'b10000) begin
      errors++; $display("FAIL oom_pulse_width got err=%b port=%b expected 0 10000", err2, port2);
    end
    cyc(16'h0001, 1'b1, 1'b1);            // size 1
    cyc(16'h1234, 1'b1, 1'b1);            // payload
    checks++;
    if (rv2 !== 1'b0 || port2 !== 5'b00000) begin
      errors++; $display("FAIL oom_release got port=%b rv=%b expected 00000 0", port2, rv2);
    end
    cyc(16'h0000, 1'b0, 1'b0);
  endtask

  // size 3 with i_ready 1,0,0,1,1,0,1 then 1: release right after the 5th transfer
  task automatic test_backpressure();
    logic [6:0] rdy;
    int         nx;
    rdy = 7'b1011001;                     // bit 0 applied first
    nx  = 0;
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'hC000, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      if (rdy[k]) nx++;
      cyc((nx == 2) ? 16'h0003 : 16'hC000, 1'b1, rdy[k]);
      checks++;
      if (rv0 !== 1'b1 || port0 !== 5'b00001) begin
        errors++; $display("FAIL bp_stable step=%0d got port=%b rv=%b expected 00001 1", k, port0, rv0);
      end
    end
    cyc(16'hBEEF, 1'b1, 1'b1);            // 5th transfer
    checks++;
    if (rv0 !== 1'b0 || port0 !== 5'b00000) begin
      errors++; $display("FAIL bp_release got port=%b rv=%b expected 00000 0", port0, rv0);
    end
    cyc(16'h0000, 1'b0, 1'b0);
  endtask

  // Packet A (3,0) size 0 followed directly by packet B (1,2)
  task automatic test_back_to_back();
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'h0000, 1'b1, 1'b1);            // release A
    checks++;
    if (rv0 !== 1'b0 || port0 !== 5'b00000 || busy0 !== 1'b0) begin
      errors++; $display("FAIL b2b_release got port=%b rv=%b busy=%b expected 00000 0 0", port0, rv0, busy0);
    end
    cyc(16'h6000, 1'b1, 1'b1);            // bubble cycle samples B
    checks++;
    if (busy0 !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got busy=%b expected 1", busy0);
    end
    cyc(16'h6000, 1'b1, 1'b1);
    checks++;
    if (port0 !== 5'b00100 || rv0 !== 1'b1) begin
      errors++; $display("FAIL b2b_north got port=%b rv=%b expected 00100 1", port0, rv0);
    end
    cyc(16'h6000, 1'b1, 1'b1);
    cyc(16'h0000, 1'b1, 1'b1);
    cyc(16'h0000, 1'b0, 1'b0);
  endtask

  // Reset in PAYLOAD abandons the packet; the next header routes normally
  task automatic test_reset_midpacket();
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'hC000, 1'b1, 1'b1);
    cyc(16'h0005, 1'b1, 1'b1);
    cyc(16'h1111, 1'b1, 1'b1);            // in PAYLOAD now
    rst = 1'b1;
    cyc(16'h1111, 1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if ({port0, rv0, busy0, err0, port1, rv1} !== 14'h0) begin
      errors++; $display("FAIL midpkt_reset got %b expected all zero", {port0, rv0, busy0, err0, port1, rv1});
    end
    cyc(16'h6000, 1'b1, 1'b1);
    cyc(16'h6000, 1'b1, 1'b1);
    checks++;
    if (port0 !== 5'b00100 || port1 !== 5'b00100 || rv0 !== 1'b1) begin
      errors++; $display("FAIL post_reset_route got xy=%b yx=%b rv=%b expected 00100 00100 1", port0, port1, rv0);
    end
    cyc(16'h6000, 1'b1, 1'b1);
    cyc(16'h0000, 1'b1, 1'b1);
    cyc(16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_flit = '0; i_valid = 1'b0; i_ready = 1'b0;
    test_reset();
    test_xy_yx();
    test_local_size0();
    test_out_of_mesh();
    test_backpressure();
    test_back_to_back();
    test_reset_midpacket();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
